// File: rtl/add_pkg.sv
// Shared defaults and elaboration helpers for the pipelined add/subtract unit.
package add_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    // Returns 0 when the geometry is illegal so the instantiating module can stop elaboration.
    function automatic int chunk_count(input int width, input int chunk);
        if (chunk < 1 || chunk > width || (width % chunk) != 0) begin
            return 0;
        end
        return width / chunk;
    endfunction

endpackage

// File: rtl/add_pipe_chunk.sv
// Combinational CHUNK-bit carry-lookahead slice: every carry is a flat
// generate/propagate sum of products rather than a ripple chain.
module add_chunk #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [CHUNK-1:0] g;
    logic [CHUNK-1:0] p;
    logic [CHUNK:0]   c;
    logic             acc;
    logic             pr;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        c    = '0;
        acc  = 1'b0;
        pr   = 1'b1;
        c[0] = ci;
        for (int i = 0; i < CHUNK; i++) begin
            acc = 1'b0;
            pr  = 1'b1;
            for (int j = i; j >= 0; j--) begin
                acc = acc | (g[j] & pr);
                pr  = pr & p[j];
            end
            c[i+1] = acc | (ci & pr);
        end
    end

    assign s     = p ^ c[CHUNK-1:0];
    assign co    = c[CHUNK];
    assign c_msb = c[CHUNK-1];

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract unit: one CHUNK-bit slice resolved per stage, carries
// handed to the next stage through registers, valid/ready with a global stall.
module add_pipe
    import add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             cout,
    output logic             ovf
);

    localparam int NCHK   = chunk_count(WIDTH, CHUNK);
    localparam int NSTAGE = (NCHK > 0) ? NCHK : 1;

    if (NCHK == 0) begin : g_param_err
        $error("add_pipe: WIDTH must be a multiple of CHUNK and 1 <= CHUNK <= WIDTH");
    end

    logic             vld_q [NSTAGE];
    logic             cy_q  [NSTAGE];
    logic [WIDTH-1:0] res_q [NSTAGE];
    logic [WIDTH-1:0] a_q   [NSTAGE];
    logic [WIDTH-1:0] b_q   [NSTAGE];
    logic             ovf_q;

    logic             vld_d [NSTAGE];
    logic             cy_d  [NSTAGE];
    logic [WIDTH-1:0] res_d [NSTAGE];
    logic [WIDTH-1:0] a_d   [NSTAGE];
    logic [WIDTH-1:0] b_d   [NSTAGE];
    logic             ovf_d;

    logic [WIDTH-1:0] a_src   [NSTAGE];
    logic [WIDTH-1:0] b_src   [NSTAGE];
    logic [WIDTH-1:0] res_src [NSTAGE];
    logic             ci_src  [NSTAGE];
    logic             vld_src [NSTAGE];

    logic [CHUNK-1:0] s_w    [NSTAGE];
    logic             co_w   [NSTAGE];
    logic             cmsb_w [NSTAGE];

    logic [WIDTH-1:0] b_eff;
    logic             advance;

    assign b_eff   = sub ? ~B : B;
    assign advance = ~vld_q[NSTAGE-1] | out_ready;

    // Operand copies shift down by CHUNK each stage so the active slice is always bits [CHUNK-1:0].
    always_comb begin
        a_src[0]   = A;
        b_src[0]   = b_eff;
        ci_src[0]  = sub ^ cin;
        vld_src[0] = in_valid;
        res_src[0] = '0;
        for (int k = 1; k < NSTAGE; k++) begin
            a_src[k]   = a_q[k-1];
            b_src[k]   = b_q[k-1];
            ci_src[k]  = cy_q[k-1];
            vld_src[k] = vld_q[k-1];
            res_src[k] = res_q[k-1];
        end
    end

    for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
        add_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a     (a_src[k][CHUNK-1:0]),
            .b     (b_src[k][CHUNK-1:0]),
            .ci    (ci_src[k]),
            .s     (s_w[k]),
            .co    (co_w[k]),
            .c_msb (cmsb_w[k])
        );
    end

    always_comb begin
        for (int k = 0; k < NSTAGE; k++) begin
            vld_d[k] = vld_src[k];
            cy_d[k]  = co_w[k];
            a_d[k]   = a_src[k] >> CHUNK;
            b_d[k]   = b_src[k] >> CHUNK;
            res_d[k] = res_src[k] | (WIDTH'(s_w[k]) << (k * CHUNK));
        end
        ovf_d = cmsb_w[NSTAGE-1] ^ co_w[NSTAGE-1];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < NSTAGE; k++) begin
                vld_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                res_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
            end
            ovf_q <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < NSTAGE; k++) begin
                vld_q[k] <= vld_d[k];
                cy_q[k]  <= cy_d[k];
                res_q[k] <= res_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
            end
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = vld_q[NSTAGE-1];
    assign Y         = res_q[NSTAGE-1];
    assign cout      = cy_q[NSTAGE-1];
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe (WIDTH=16, CHUNK=4): vector table, streaming with a stall,
// bubbles, reset mid-flight and random traffic, all scored through a queue.
module tb_add_pipe;

    localparam int W  = 16;
    localparam int C  = 4;
    localparam int NS = W / C;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] Y;
    logic         cout;
    logic         ovf;

    add_pipe #(.WIDTH(W), .CHUNK(C)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Y         (Y),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] y;
        logic         c;
        logic         o;
    } res_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic         sb;
        res_t         exp;
    } vec_t;

    typedef struct {
        res_t r;
        int   cyc;
    } sb_t;

    sb_t  sb_q[$];
    res_t drv_exp;
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    bit   check_lat = 1'b1;
    vec_t vecs[11];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic ci, input logic sb);
        logic [W:0] full;
        res_t       r;
        if (!sb) begin
            full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            r.o  = (a[W-1] == b[W-1]) && (full[W-1] != a[W-1]);
        end else begin
            full = {1'b0, a} + {1'b0, ~b} + {{W{1'b0}}, ~ci};
            r.o  = (a[W-1] != b[W-1]) && (full[W-1] != a[W-1]);
        end
        r.y = full[W-1:0];
        r.c = full[W];
        return r;
    endfunction

    function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                                input logic sb, input logic [W-1:0] y, input logic co,
                                input logic ov);
        vec_t v;
        v.a     = a;
        v.b     = b;
        v.ci    = ci;
        v.sb    = sb;
        v.exp.y = y;
        v.exp.c = co;
        v.exp.o = ov;
        return v;
    endfunction

    // Scoreboard: both transfers are decided at the next rising edge, so look at the falling edge.
    always @(negedge clk) begin
        sb_t e;
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("spurious_out", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check("result", {46'd0, Y, cout, ovf}, {46'd0, e.r});
                    if (check_lat) check("latency", 64'(cyc - e.cyc), 64'(NS));
                end
            end
            if (in_valid && in_ready) begin
                e.r   = drv_exp;
                e.cyc = cyc;
                sb_q.push_back(e);
            end
        end
    end

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                         input logic sb, input logic v, input res_t e);
        int n;
        A        = a;
        B        = b;
        cin      = ci;
        sub      = sb;
        in_valid = v;
        drv_exp  = e;
        n        = 0;
        @(negedge clk);
        while (v && !in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (n >= 50) check("accept_timeout", 64'd0, 64'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        in_valid = 1'b0;
        n        = 0;
        while (sb_q.size() != 0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0]  = mk(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b0);
        vecs[1]  = mk(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
        vecs[2]  = mk(16'h0001, 16'h000E, 1'b0, 1'b1, 16'hFFF3, 1'b0, 1'b0);
        vecs[3]  = mk(16'h0001, 16'h000E, 1'b1, 1'b1, 16'hFFF2, 1'b0, 1'b0);
        vecs[4]  = mk(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        vecs[5]  = mk(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        vecs[6]  = mk(16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
        vecs[7]  = mk(16'h000F, 16'h0001, 1'b0, 1'b0, 16'h0010, 1'b0, 1'b0);
        vecs[8]  = mk(16'h0FFF, 16'h0001, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0);
        vecs[9]  = mk(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);
        vecs[10] = mk(16'h1234, 16'h0FFF, 1'b1, 1'b1, 16'h0234, 1'b1, 1'b0);

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        A         = '0;
        B         = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        drv_exp   = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y", 64'(Y), 64'd0);
        check("rst_cout_ovf", {62'd0, cout, ovf}, 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;

        // Table vectors, back to back
        for (int i = 0; i < 11; i++) begin
            drive(vecs[i].a, vecs[i].b, vecs[i].ci, vecs[i].sb, 1'b1, vecs[i].exp);
        end
        drain();

        // Stream of 8 adds with a 3-cycle output stall after the 4th acceptance
        check_lat = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            a = W'(i);
            b = W'(16'h0FFF * i);
            if (i == 5) begin
                out_ready = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("stall_in_ready", 64'(in_ready), 64'd0);
                    check("stall_out_valid", 64'(out_valid), 64'd1);
                    if (sb_q.size() == 0) check("stall_queue", 64'd0, 64'd1);
                    else check("stall_y", 64'(Y), 64'(sb_q[0].r.y));
                    @(posedge clk);
                    #1;
                end
                out_ready = 1'b1;
            end
            drive(a, b, 1'b0, 1'b0, 1'b1, model(a, b, 1'b0, 1'b0));
        end
        drain();
        check_lat = 1'b1;

        // Alternating valid/bubble: latency and no-spurious checks pin the pattern
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] a;
            a = W'(16'h1111 * i);
            drive(a, 16'h0F0F, i[0], i[1], 1'b1, model(a, 16'h0F0F, i[0], i[1]));
            drive(16'hDEAD, 16'hBEEF, 1'b0, 1'b0, 1'b0, '0);
        end
        drain();

        // Reset with operations in flight
        drive(16'h1111, 16'h2222, 1'b0, 1'b0, 1'b1, model(16'h1111, 16'h2222, 1'b0, 1'b0));
        drive(16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1, model(16'h3333, 16'h4444, 1'b0, 1'b0));
        rst_n = 1'b0;
        drive(16'h5555, 16'h6666, 1'b0, 1'b0, 1'b1, model(16'h5555, 16'h6666, 1'b0, 1'b0));
        rst_n    = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < NS; i++) begin
            @(negedge clk);
            check("postrst_out_valid", 64'(out_valid), 64'd0);
            check("postrst_y", 64'(Y), 64'd0);
        end
        check("postrst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        drive(16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, '{y: 16'h0001, c: 1'b0, o: 1'b0});
        drain();

        // Random traffic with random bubbles
        for (int i = 0; i < 32; i++) begin
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic         ci;
            logic         sb;
            logic         v;
            a  = W'($urandom);
            b  = W'($urandom);
            ci = 1'($urandom_range(0, 1));
            sb = 1'($urandom_range(0, 1));
            v  = ($urandom_range(0, 3) != 0);
            drive(a, b, ci, sb, v, model(a, b, ci, sb));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
